// File: rtl/conv_sequencer_pkg.sv
// Shared types and defaults for the convolution frame sequencer.
package conv_sequencer_pkg;

    localparam int BW2_DEF = 16;
    localparam int XS_DEF  = 32;
    localparam int WS_DEF  = 5;
    localparam int LAT_DEF = 6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// Bus bundle between the weight/pixel sources, the sequencer and the convolution datapath.
interface conv_sequencer_if
    import conv_sequencer_pkg::*;
#(
    parameter int BW2 = BW2_DEF
) ();

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on valid, and data is only meaningful while valid is high.
    logic           iStart;
    logic           iKeepW;
    logic           iWValid;
    logic [7:0]     iWData;
    logic           oWReady;
    logic           iPixValid;
    logic [7:0]     iPix;
    logic           oPixReady;
    logic           oWren;
    logic [4:0]     oADDR;
    logic [7:0]     oWeight;
    logic [7:0]     oX;
    logic [BW2-1:0] iPsum;
    logic           oOutValid;
    logic [BW2-1:0] oOut;
    logic           oLast;
    logic           oBusy;
    logic           oDone;
    logic           oErr;
    state_t         oState;

    modport slave (
        input  iStart, iKeepW, iWValid, iWData, iPixValid, iPix, iPsum,
        output oWReady, oPixReady, oWren, oADDR, oWeight, oX,
               oOutValid, oOut, oLast, oBusy, oDone, oErr, oState
    );

    modport master (
        output iStart, iKeepW, iWValid, iWData, iPixValid, iPix, iPsum,
        input  oWReady, oPixReady, oWren, oADDR, oWeight, oX,
               oOutValid, oOut, oLast, oBusy, oDone, oErr, oState
    );

endinterface

// File: rtl/conv_sequencer_tag_delay.sv
// LAT-deep shift register carrying {tag, last} alongside the datapath latency.
module conv_sequencer_tag_delay #(
    parameter int LAT = 6
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iClr,
    input  logic [1:0] iD,
    output logic [1:0] oQ
);

    logic [1:0] pipe [LAT];

    always_ff @(posedge iCLK) begin
        if (iRST || iClr) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= 2'b00;
        end else begin
            pipe[0] <= iD;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign oQ = pipe[LAT-1];

endmodule

// File: rtl/conv_sequencer.sv
// Frame controller: loads kernel weights, streams a raster frame, and qualifies full-window psums.
module conv_sequencer
    import conv_sequencer_pkg::*;
#(
    parameter int XS  = XS_DEF,
    parameter int WS  = WS_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic             iCLK,
    input  logic             iRST,
    conv_sequencer_if.slave  bus
);

    localparam int NW = WS * WS;
    localparam int CW = cnt_w(XS);
    localparam int DW = cnt_w(LAT);

    state_t        state;
    logic          loaded;
    logic [4:0]    k;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [DW-1:0] dcnt;
    logic [1:0]    tag_out;

    logic p_hs;
    logic underrun;
    logic at_last_pix;
    logic tag_in;
    logic emit;

    assign p_hs        = (state == S_STREAM) && bus.iPixValid;
    assign underrun    = (state == S_STREAM) && !bus.iPixValid;
    assign at_last_pix = (row == CW'(XS-1)) && (col == CW'(XS-1));
    assign tag_in      = p_hs && (row >= CW'(WS-1)) && (col >= CW'(WS-1));
    // An underrun kills the result leaving the pipe on the same edge, so nothing follows the error.
    assign emit        = tag_out[1] && !underrun;

    conv_sequencer_tag_delay #(.LAT(LAT)) u_tag (
        .iCLK (iCLK),
        .iRST (iRST),
        .iClr (underrun),
        .iD   ({tag_in, p_hs && at_last_pix}),
        .oQ   (tag_out)
    );

    assign bus.oWReady   = (state == S_LOAD);
    assign bus.oPixReady = (state == S_STREAM);
    assign bus.oBusy     = (state != S_IDLE);
    assign bus.oDone     = (state == S_DONE);
    assign bus.oState    = state;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state         <= S_IDLE;
            loaded        <= 1'b0;
            k             <= '0;
            col           <= '0;
            row           <= '0;
            dcnt          <= '0;
            bus.oWren     <= 1'b0;
            bus.oADDR     <= '0;
            bus.oWeight   <= '0;
            bus.oX        <= '0;
            bus.oOutValid <= 1'b0;
            bus.oOut      <= '0;
            bus.oLast     <= 1'b0;
            bus.oErr      <= 1'b0;
        end else begin
            bus.oWren     <= 1'b0;
            bus.oOutValid <= emit;
            bus.oLast     <= emit && tag_out[0];
            if (emit) bus.oOut <= bus.iPsum;

            case (state)
                S_IDLE: begin
                    if (bus.iStart) begin
                        bus.oErr <= 1'b0;
                        k        <= '0;
                        col      <= '0;
                        row      <= '0;
                        dcnt     <= '0;
                        state    <= (bus.iKeepW && loaded) ? S_STREAM : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.iWValid) begin
                        bus.oWren   <= 1'b1;
                        bus.oADDR   <= k;
                        bus.oWeight <= bus.iWData;
                        if (k == 5'(NW-1)) begin
                            loaded <= 1'b1;
                            state  <= S_STREAM;
                        end else begin
                            k <= k + 5'd1;
                        end
                    end
                end
                S_STREAM: begin
                    if (!bus.iPixValid) begin
                        bus.oErr <= 1'b1;
                        state    <= S_ERR;
                    end else begin
                        bus.oX <= bus.iPix;
                        if (col == CW'(XS-1)) begin
                            col <= '0;
                            if (row == CW'(XS-1)) begin
                                row   <= '0;
                                state <= S_DRAIN;
                            end else begin
                                row <= row + CW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (dcnt == DW'(LAT-1)) begin
                        dcnt  <= '0;
                        state <= S_DONE;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer with a stand-in pipelined datapath.
module tb_conv_sequencer;
    import conv_sequencer_pkg::*;

    localparam int BW2 = 16;
    localparam int XS  = 32;
    localparam int WS  = 5;
    localparam int LAT = 6;
    localparam int NPIX = XS * XS;
    localparam int NRES = (XS - WS + 1) * (XS - WS + 1);

    logic iCLK;
    logic iRST;

    conv_sequencer_if #(.BW2(BW2)) bus ();

    conv_sequencer #(.XS(XS), .WS(WS), .LAT(LAT)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Stand-in datapath: psum = 25 * pixel, arriving LAT-1 register stages after oX.
    logic [7:0] dl [LAT-1];
    always @(posedge iCLK) begin
        dl[0] <= bus.oX;
        for (int i = 1; i < LAT-1; i++) dl[i] <= dl[i-1];
    end
    logic signed [BW2-1:0] x_ext;
    assign x_ext     = BW2'($signed(dl[LAT-2]));
    assign bus.iPsum = x_ext * BW2'(25);

    // ---------------- scoreboard state ----------------
    logic [BW2:0]  exp_q[$];
    logic [12:0]   w_q[$];
    logic [BW2:0]  r_exp;
    logic [12:0]   w_exp;
    int n_cmp, n_err;
    int cyc, res_cnt, done_cnt, wren_cnt, first_cyc, done_cyc;
    bit tb_loaded;

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        res_cnt = 0; done_cnt = 0; wren_cnt = 0; first_cyc = -1; done_cyc = -1;
        tb_loaded = 1'b0;
    end

    // Monitor: compares every weight write and every qualified result against the queues.
    always @(negedge iCLK) begin
        if (bus.oWren) begin
            n_cmp++; wren_cnt++;
            if (w_q.size() == 0) begin
                n_err++;
                $display("FAIL wren_unexpected got=%0h exp=none", {bus.oADDR, bus.oWeight});
            end else begin
                w_exp = w_q.pop_front();
                if ({bus.oADDR, bus.oWeight} !== w_exp) begin
                    n_err++;
                    $display("FAIL weight_write got=%0h exp=%0h", {bus.oADDR, bus.oWeight}, w_exp);
                end
            end
        end
        if (bus.oOutValid) begin
            n_cmp++; res_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL result_unexpected got=%0h exp=none", {bus.oLast, bus.oOut});
            end else begin
                r_exp = exp_q.pop_front();
                if ({bus.oLast, bus.oOut} !== r_exp) begin
                    n_err++;
                    $display("FAIL result got=%0h exp=%0h", {bus.oLast, bus.oOut}, r_exp);
                end
            end
        end
        if (bus.oDone) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    end

    // ---------------- driver ----------------
    // wmode: 0 = weights 1..25 back-to-back, 1 = all ones, 2 = random with gaps.
    // pmode: 0 = random pixels, 1 = all ones. drop_at/rst_at/start_at < 0 disable the event.
    task automatic run_frame(input bit keepw, input int wmode, input int pmode,
                             input int drop_at, input int rst_at, input int start_at);
        int k, guard, r, c, rc, t, pix132_cyc, last_cyc, pv;
        bit do_load, early, ready_bad, wready_bad;
        logic [7:0] w, pix;
        logic [BW2-1:0] e;
        res_cnt = 0; done_cnt = 0; wren_cnt = 0; first_cyc = -1; done_cyc = -1;
        pix132_cyc = -1; last_cyc = -1;
        do_load = !(keepw && tb_loaded);

        bus.iStart = 1'b1; bus.iKeepW = keepw;
        @(posedge iCLK); #1;
        bus.iStart = 1'b0; bus.iKeepW = 1'b0;

        n_cmp++;
        if (bus.oErr !== 1'b0) begin
            n_err++; $display("FAIL err_clear_on_start got=%b exp=0", bus.oErr);
        end
        n_cmp++;
        if ({bus.oWReady, bus.oPixReady} !== (do_load ? 2'b10 : 2'b01)) begin
            n_err++;
            $display("FAIL start_path got=%b exp=%b", {bus.oWReady, bus.oPixReady},
                     (do_load ? 2'b10 : 2'b01));
        end

        if (do_load) begin
            k = 0; guard = 0; early = 1'b0;
            while (k < WS*WS && guard < 400) begin
                w = (wmode == 0) ? 8'(k + 1) : (wmode == 1) ? 8'd1 : 8'($urandom_range(0, 255));
                bus.iWValid = (wmode == 2) ? ((guard % 2) == 0) : 1'b1;
                bus.iWData  = w;
                if (bus.oPixReady) early = 1'b1;
                @(posedge iCLK);
                if (bus.iWValid && bus.oWReady) begin
                    w_q.push_back({5'(k), w});
                    k++;
                end
                guard++;
                #1;
            end
            bus.iWValid = 1'b0;
            n_cmp++;
            if (k != WS*WS || early) begin
                n_err++; $display("FAIL load got=%0d early=%b exp=%0d early=0", k, early, WS*WS);
                return;
            end
            n_cmp++;
            if (bus.oPixReady !== 1'b1) begin
                n_err++; $display("FAIL stream_after_load got=%b exp=1", bus.oPixReady);
            end
            tb_loaded = 1'b1;
        end

        ready_bad = 1'b0; wready_bad = 1'b0;
        for (int idx = 0; idx < NPIX; idx++) begin
            r = idx / XS; c = idx % XS;
            if (idx == rst_at) begin
                iRST = 1'b1; bus.iPixValid = 1'b0;
                @(posedge iCLK); #1;
                exp_q.delete(); tb_loaded = 1'b0;
                n_cmp++;
                if ({bus.oWReady, bus.oPixReady, bus.oWren, bus.oADDR, bus.oWeight, bus.oX,
                     bus.oOutValid, bus.oOut, bus.oLast, bus.oBusy, bus.oDone, bus.oErr} !== 45'd0
                    || bus.oState !== S_IDLE) begin
                    n_err++; $display("FAIL reset_mid_frame got busy=%b state=%0d exp=all zero/idle",
                                      bus.oBusy, bus.oState);
                end
                iRST = 1'b0;
                return;
            end
            if (idx == drop_at) begin
                bus.iPixValid = 1'b0;
                @(posedge iCLK); #1;
                exp_q.delete();
                n_cmp++;
                if (bus.oErr !== 1'b1 || bus.oState !== S_ERR) begin
                    n_err++; $display("FAIL underrun got err=%b state=%0d exp err=1 state=%0d",
                                      bus.oErr, bus.oState, S_ERR);
                end
                rc = res_cnt;
                repeat (LAT + 4) @(posedge iCLK);
                #1;
                n_cmp++;
                if (bus.oBusy !== 1'b0 || bus.oErr !== 1'b1 || res_cnt != rc || done_cnt != 0) begin
                    n_err++; $display("FAIL after_underrun got busy=%b err=%b res=%0d done=%0d exp 0 1 %0d 0",
                                      bus.oBusy, bus.oErr, res_cnt, done_cnt, rc);
                end
                return;
            end
            pix = (pmode == 1) ? 8'd1 : 8'($urandom_range(0, 255));
            bus.iPixValid = 1'b1;
            bus.iPix      = pix;
            if (idx == start_at) bus.iStart = 1'b1;
            if (bus.oPixReady !== 1'b1) ready_bad = 1'b1;
            if (bus.oWReady !== 1'b0) wready_bad = 1'b1;
            if (r >= WS-1 && c >= WS-1) begin
                pv = int'($signed(pix));
                e  = BW2'(pv * 25);
                exp_q.push_back({(idx == NPIX-1), e});
            end
            @(posedge iCLK);
            if (idx == (WS-1)*XS + (WS-1)) pix132_cyc = cyc;
            if (idx == NPIX-1) last_cyc = cyc;
            #1;
            bus.iStart = 1'b0;
        end
        bus.iPixValid = 1'b0;

        t = 0;
        while (done_cnt == 0 && t < LAT + 20) begin
            @(posedge iCLK); #1; t++;
        end
        @(posedge iCLK); #1;

        n_cmp++;
        if (ready_bad || wready_bad) begin
            n_err++; $display("FAIL ready_during_stream got pix_gap=%b wready=%b exp 0 0", ready_bad, wready_bad);
        end
        n_cmp++;
        if (res_cnt != NRES || exp_q.size() != 0) begin
            n_err++; $display("FAIL result_count got=%0d left=%0d exp=%0d left=0", res_cnt, exp_q.size(), NRES);
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++; $display("FAIL done_count got=%0d exp=1", done_cnt);
        end
        n_cmp++;
        if (first_cyc - pix132_cyc != LAT) begin
            n_err++; $display("FAIL first_result_latency got=%0d exp=%0d", first_cyc - pix132_cyc, LAT);
        end
        n_cmp++;
        if (done_cyc - last_cyc != LAT) begin
            n_err++; $display("FAIL done_latency got=%0d exp=%0d", done_cyc - last_cyc, LAT);
        end
        n_cmp++;
        if (bus.oBusy !== 1'b0) begin
            n_err++; $display("FAIL idle_after_frame got busy=%b exp=0", bus.oBusy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        iRST = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;
        n_cmp++;
        if ({bus.oWReady, bus.oPixReady, bus.oWren, bus.oADDR, bus.oWeight, bus.oX,
             bus.oOutValid, bus.oOut, bus.oLast, bus.oBusy, bus.oDone, bus.oErr} !== 45'd0) begin
            n_err++; $display("FAIL reset_outputs got=%0h exp=0",
                {bus.oWReady, bus.oPixReady, bus.oWren, bus.oADDR, bus.oWeight, bus.oX,
                 bus.oOutValid, bus.oOut, bus.oLast, bus.oBusy, bus.oDone, bus.oErr});
        end
        iRST = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        n_cmp++;
        if (bus.oState !== S_IDLE || bus.oBusy !== 1'b0) begin
            n_err++; $display("FAIL reset_idle got state=%0d exp=%0d", bus.oState, S_IDLE);
        end
    endtask

    task automatic test_load_back_to_back();
        run_frame(1'b0, 0, 0, -1, -1, -1);
        n_cmp++;
        if (wren_cnt != WS*WS) begin
            n_err++; $display("FAIL wren_count_b2b got=%0d exp=%0d", wren_cnt, WS*WS);
        end
    endtask

    task automatic test_full_frame_ones();
        run_frame(1'b0, 1, 1, -1, -1, -1);
        n_cmp++;
        if (bus.oOut !== BW2'(25) || bus.oOutValid !== 1'b0) begin
            n_err++; $display("FAIL out_hold got=%0d valid=%b exp=25 valid=0", bus.oOut, bus.oOutValid);
        end
    endtask

    task automatic test_weight_gaps();
        run_frame(1'b0, 2, 0, -1, -1, -1);
        n_cmp++;
        if (wren_cnt != WS*WS) begin
            n_err++; $display("FAIL wren_count_gaps got=%0d exp=%0d", wren_cnt, WS*WS);
        end
    endtask

    task automatic test_underrun();
        run_frame(1'b1, 0, 0, 500, -1, -1);
        run_frame(1'b1, 0, 0, -1, -1, -1);
        n_cmp++;
        if (wren_cnt != 0) begin
            n_err++; $display("FAIL keepw_reload got=%0d exp=0", wren_cnt);
        end
    endtask

    task automatic test_reset_mid_stream();
        run_frame(1'b1, 0, 0, -1, 300, -1);
        repeat (3) @(posedge iCLK);
        #1;
        run_frame(1'b1, 0, 0, -1, -1, -1);
        n_cmp++;
        if (wren_cnt != WS*WS) begin
            n_err++; $display("FAIL reload_after_reset got=%0d exp=%0d", wren_cnt, WS*WS);
        end
    endtask

    task automatic test_start_while_busy();
        run_frame(1'b1, 0, 0, -1, -1, 400);
        n_cmp++;
        if (wren_cnt != 0) begin
            n_err++; $display("FAIL busy_start_reload got=%0d exp=0", wren_cnt);
        end
    endtask

    initial begin
        iRST = 1'b1;
        bus.iStart = 1'b0; bus.iKeepW = 1'b0;
        bus.iWValid = 1'b0; bus.iWData = 8'd0;
        bus.iPixValid = 1'b0; bus.iPix = 8'd0;
        test_reset();
        test_load_back_to_back();
        test_full_frame_ones();
        test_weight_gaps();
        test_underrun();
        test_reset_mid_stream();
        test_start_while_busy();
        repeat (4) @(posedge iCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
